// File: rtl/delay_responder_pkg.sv
// -----------------------------------------------------------------------------
// delay_responder_pkg
//
// Shared constants and helpers for the fixed-latency responder.
//   LATENCY_DEF / DW_DEF / MAX_OUT_DEF : default parameter values
//   calc_tw()                          : timestamp width for a given latency
//   entry_t                            : FIFO entry layout {due, data} at the
//                                        default widths. The top re-declares the
//                                        same layout at its actual widths.
// -----------------------------------------------------------------------------
package delay_responder_pkg;

  localparam int LATENCY_DEF = 4;
  localparam int DW_DEF      = 8;
  localparam int MAX_OUT_DEF = 4;

  // Two extra bits keep 2^TW above 2*LATENCY. An equality compare between the
  // free-running timestamp and a due time can then never alias an older or a
  // newer due time.
  function automatic int calc_tw(input int latency);
    return $clog2(latency) + 2;
  endfunction

  localparam int TW_DEF = calc_tw(LATENCY_DEF);

  typedef struct packed {
    logic [TW_DEF-1:0] due;
    logic [DW_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/delay_responder_if.sv
// -----------------------------------------------------------------------------
// delay_responder_if
//
// Request/response bundle for delay_responder.
//   a, a_data             : request strobe and payload (master -> slave)
//   b, b_data             : response strobe and payload (slave -> master)
//   drop                  : request rejected because capacity was full
//   outstanding [OW-1:0]  : accepted requests not yet answered
// OW must equal $clog2(MAX_OUT+1) of the attached responder.
// -----------------------------------------------------------------------------
interface delay_responder_if
  import delay_responder_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = $clog2(MAX_OUT_DEF + 1)
);

  logic          a;
  logic [DW-1:0] a_data;
  logic          b;
  logic [DW-1:0] b_data;
  logic          drop;
  logic [OW-1:0] outstanding;

  modport master (
    output a, a_data,
    input  b, b_data, drop, outstanding
  );

  modport slave (
    input  a, a_data,
    output b, b_data, drop, outstanding
  );

endinterface

// File: rtl/delay_responder_fifo.sv
// -----------------------------------------------------------------------------
// delay_responder_fifo
//
// Synchronous FIFO with an asynchronous active-low reset and a look-ahead head.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, wr_data    : write request. It is honoured when not full, or when
//                      full and a pop happens at the same edge.
//   pop              : remove the head entry. It is ignored when empty.
//   head             : current head entry. It is only meaningful when !empty.
//   full, empty      : occupancy flags
//   count [CW-1:0]   : registered occupancy, 0..DEPTH
// Any DEPTH >= 1 is supported. The pointers wrap explicitly, so DEPTH does not
// need to be a power of two.
// -----------------------------------------------------------------------------
module delay_responder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push,  do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a value before any branch. If a path left one
    // unassigned, always_comb would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    do_pop  = pop && (count_q != '0);
    // When full, a write is only legal if the head leaves at the same edge.
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, and the order of the statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset. Validity comes entirely
  // from the reset pointers and count, and an unreset array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/delay_responder.sv
// -----------------------------------------------------------------------------
// delay_responder
//
// Fixed-latency request/response stage. A request sampled with a=1 at edge t
// comes back as b=1 with the same payload, sampled at edge t+LATENCY. Up to
// MAX_OUT requests can be in flight, and they return in order. A request that
// arrives while the FIFO is full, with no pop at that edge, is discarded and
// flagged on drop one cycle later.
//
// Parameters: LATENCY (>=1), DW (payload width), MAX_OUT (>=1, FIFO depth)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : delay_responder_if.slave
//                (a, a_data in; b, b_data, drop, outstanding out)
//
// Optional build macro: DELAY_RESPONDER_ASSERT_EN embeds concurrent assertions
// for the latency contract. They do not change behaviour.
// -----------------------------------------------------------------------------
module delay_responder
  import delay_responder_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  delay_responder_if.slave   bus
);

  localparam int TW = calc_tw(LATENCY);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int EW = TW + DW;

  // With LATENCY=1 the response has to be registered at the request's own
  // edge. The entry would only land in the FIFO at that same edge, so the
  // request bypasses the FIFO and goes straight to the output registers.
  localparam bit BYPASS = (LATENCY == 1);

  // The head is popped at the edge where its due time equals now. b is then
  // registered at that edge, which is why the offset is LATENCY-1.
  localparam logic [TW-1:0] DUE_OFFSET = TW'(LATENCY - 1);

  typedef struct packed {
    logic [TW-1:0] due;
    logic [DW-1:0] data;
  } slot_t;

  logic [TW-1:0] now_q,    now_d;
  logic          b_q,      b_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic          drop_q,   drop_d;

  slot_t         in_slot;
  slot_t         head;
  logic [EW-1:0] head_bits;
  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  delay_responder_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (in_slot),
    .pop     (fifo_pop),
    .head    (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head = slot_t'(head_bits);

  always_comb begin
    now_d    = now_q + TW'(1);

    // Due times are pushed in increasing order, so only the head can be due.
    fifo_pop = !fifo_empty && (head.due == now_q);

    in_slot.due  = now_q + DUE_OFFSET;
    in_slot.data = bus.a_data;

    fifo_push = !BYPASS && bus.a && (!fifo_full || fifo_pop);
    drop_d    = !BYPASS && bus.a && fifo_full && !fifo_pop;

    b_d      = 1'b0;
    b_data_d = '0;
    if (fifo_pop) begin
      b_d      = 1'b1;
      b_data_d = head.data;
    end else if (BYPASS && bus.a) begin
      b_d      = 1'b1;
      b_data_d = bus.a_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q    <= '0;
      b_q      <= 1'b0;
      b_data_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      now_q    <= now_d;
      b_q      <= b_d;
      b_data_q <= b_data_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.b           = b_q;
  assign bus.b_data      = b_data_q;
  assign bus.drop        = drop_q;
  assign bus.outstanding = fifo_count;

`ifdef DELAY_RESPONDER_ASSERT_EN
  logic req_taken;
  assign req_taken = bus.a && (BYPASS || !fifo_full || fifo_pop);

  a_latency : assert property (@(posedge clk) disable iff (!rst_n)
    req_taken |-> ##LATENCY bus.b)
    else $error("[%0t] delay_responder: accepted request not answered after %0d edges",
                $time, LATENCY);

  // Bypassed responses never occupy the FIFO, so this check only applies when
  // responses come out of the FIFO.
  if (!BYPASS) begin : g_b_source
    a_b_source : assert property (@(posedge clk) disable iff (!rst_n)
      bus.b |-> ($past(fifo_count) > '0))
      else $error("[%0t] delay_responder: response with nothing outstanding", $time);
  end

  a_no_spurious_drop : assert property (@(posedge clk) disable iff (!rst_n)
    ($past(fifo_count) < CW'(MAX_OUT)) |-> !bus.drop)
    else $error("[%0t] delay_responder: drop while below capacity", $time);
`else
  // Assertions compiled out; functional logic is unchanged.
`endif

endmodule

// File: tb/tb_delay_responder.sv
// -----------------------------------------------------------------------------
// tb_delay_responder
//
// Three responder instances:
//   0: LATENCY=4, MAX_OUT=4
//   1: LATENCY=4, MAX_OUT=2
//   2: LATENCY=1, MAX_OUT=4
// A queue-based reference model predicts b, b_data, drop and outstanding for
// every edge of the active instance. Edge e counts from the first edge after
// that instance's reset is released. Outputs are sampled on the falling edge,
// so the value seen is the one present at the next rising edge e.
// -----------------------------------------------------------------------------
module tb_delay_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      a_v;
  logic [2:0][7:0] d_v;
  logic [2:0]      rstn_v;
  logic [2:0]      b_v;
  logic [2:0][7:0] bd_v;
  logic [2:0]      drop_v;
  logic [2:0][2:0] out_v;

  delay_responder_if #(.DW(8), .OW(3)) if0 ();
  delay_responder_if #(.DW(8), .OW(2)) if1 ();
  delay_responder_if #(.DW(8), .OW(3)) if2 ();

  assign if0.a = a_v[0];  assign if0.a_data = d_v[0];
  assign if1.a = a_v[1];  assign if1.a_data = d_v[1];
  assign if2.a = a_v[2];  assign if2.a_data = d_v[2];

  assign b_v[0] = if0.b;  assign bd_v[0] = if0.b_data;  assign drop_v[0] = if0.drop;
  assign b_v[1] = if1.b;  assign bd_v[1] = if1.b_data;  assign drop_v[1] = if1.drop;
  assign b_v[2] = if2.b;  assign bd_v[2] = if2.b_data;  assign drop_v[2] = if2.drop;
  assign out_v[0] = if0.outstanding;
  assign out_v[1] = {1'b0, if1.outstanding};
  assign out_v[2] = if2.outstanding;

  delay_responder #(.LATENCY(4), .DW(8), .MAX_OUT(4)) u_dut0 (
    .clk(clk), .rst_n(rstn_v[0]), .bus(if0));
  delay_responder #(.LATENCY(4), .DW(8), .MAX_OUT(2)) u_dut1 (
    .clk(clk), .rst_n(rstn_v[1]), .bus(if1));
  delay_responder #(.LATENCY(1), .DW(8), .MAX_OUT(4)) u_dut2 (
    .clk(clk), .rst_n(rstn_v[2]), .bus(if2));

  int lat_of [3] = '{4, 4, 1};
  int cap_of [3] = '{4, 2, 4};

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  bit   drop_pend;
  int   e;
  int   cur;
  int   n_vec;
  int   n_err;

  logic       s_b, s_drop;
  logic [7:0] s_bd;
  int         s_out;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s (dut %0d, edge %0d): got 0x%0h, want 0x%0h",
               name, cur, e, act, exp_v);
    end
  endtask

  // One clock cycle: sample and check the values for edge e, then drive the
  // inputs for edge e and advance the model.
  task automatic cycle(input logic a, input logic [7:0] d, input logic rst);
    bit         eb;
    logic [7:0] ebd;
    bit         popn;
    bit         acc;
    exp_t       ent;
    @(negedge clk);
    s_b    = b_v[cur];
    s_bd   = bd_v[cur];
    s_drop = drop_v[cur];
    s_out  = int'(out_v[cur]);
    eb  = 1'b0;
    ebd = 8'h00;
    if (sb.size() > 0 && sb[0].due == e) begin
      eb  = 1'b1;
      ebd = sb[0].data;
      void'(sb.pop_front());
    end
    check("b",           int'(s_b),    int'(eb));
    check("b_data",      int'(s_bd),   int'(ebd));
    check("drop",        int'(s_drop), int'(drop_pend));
    check("outstanding", s_out,        sb.size());
    a_v[cur] = a;
    d_v[cur] = d;
    if (!rst) begin
      rstn_v[cur] = 1'b0;
      sb.delete();
      drop_pend = 1'b0;
      #1;
      check("rst_b",           int'(b_v[cur]),    0);
      check("rst_b_data",      int'(bd_v[cur]),   0);
      check("rst_drop",        int'(drop_v[cur]), 0);
      check("rst_outstanding", int'(out_v[cur]),  0);
    end else begin
      rstn_v[cur] = 1'b1;
      // The DUT pops at edge e when the head's response is due at edge e+1.
      popn = (sb.size() > 0) && (sb[0].due == e + 1);
      acc  = a && ((sb.size() < cap_of[cur]) || popn);
      if (acc) begin
        ent.due  = e + lat_of[cur];
        ent.data = d;
        sb.push_back(ent);
      end
      drop_pend = a && !acc;
    end
    e++;
  endtask

  task automatic start_test(input int k);
    cur = k;
    sb.delete();
    drop_pend = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    e = 0;
  endtask

  typedef struct {
    logic       a;
    logic [7:0] d;
    logic       xb;
    logic [7:0] xbd;
    logic       xdrop;
    int         xout;
  } vec_t;

  vec_t t1 [10];

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cur    = 0;
    e      = 0;
    a_v    = '0;
    d_v    = '0;
    rstn_v = '0;

    // Reset values on all instances.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cur = k;
      check("reset_b",           int'(b_v[k]),    0);
      check("reset_b_data",      int'(bd_v[k]),   0);
      check("reset_drop",        int'(drop_v[k]), 0);
      check("reset_outstanding", int'(out_v[k]),  0);
    end
    rstn_v = '1;

    // Test 1: single request 0x5A at edge 2. Table with explicit expectations.
    for (int i = 0; i < 10; i++) t1[i] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
    t1[2].a = 1'b1;  t1[2].d = 8'h5A;
    t1[3].xout = 1;  t1[4].xout = 1;  t1[5].xout = 1;
    t1[6].xb = 1'b1; t1[6].xbd = 8'h5A;
    start_test(0);
    for (int i = 0; i < 10; i++) begin
      cycle(t1[i].a, t1[i].d, 1'b1);
      check("t1_b",           int'(s_b),    int'(t1[i].xb));
      check("t1_b_data",      int'(s_bd),   int'(t1[i].xbd));
      check("t1_drop",        int'(s_drop), int'(t1[i].xdrop));
      check("t1_outstanding", s_out,        t1[i].xout);
    end

    // Test 2: back-to-back requests 0x11..0x44 at edges 2..5.
    start_test(0);
    for (int i = 0; i < 12; i++) begin
      cycle((i >= 2 && i <= 5), 8'(8'h11 * (i - 1)), 1'b1);
      if (i >= 6 && i <= 9) begin
        check("t2_b_seq",    int'(s_b),  1);
        check("t2_data_seq", int'(s_bd), 8'h11 * (i - 5));
      end
    end

    // Test 3: capacity 2, requests at edges 2,3,4. The third one is dropped.
    start_test(1);
    for (int i = 0; i < 10; i++) begin
      cycle((i >= 2 && i <= 4), 8'(8'hC0 + i), 1'b1);
      if (i == 5) check("t3_drop_edge5", int'(s_drop), 1);
      check("t3_out_le_cap", int'(s_out <= 2), 1);
    end
    // Continuous requests exercise push-while-full-with-pop; then a random mix.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    for (int i = 0; i < 6; i++)  cycle(1'b0, 8'h00, 1'b1);

    // Test 4: reset while a request is in flight, with a held high during reset.
    start_test(0);
    for (int i = 0; i < 15; i++) begin
      if (i == 2)       cycle(1'b1, 8'h77, 1'b1);
      else if (i == 4)  cycle(1'b1, 8'hEE, 1'b0);
      else if (i == 8)  cycle(1'b1, 8'h99, 1'b1);
      else              cycle(1'b0, 8'h00, 1'b1);
      if (i == 6)  check("t4_no_stale_b", int'(s_b), 0);
      if (i == 12) begin
        check("t4_b_after_rst",    int'(s_b),  1);
        check("t4_data_after_rst", int'(s_bd), 8'h99);
      end
    end

    // Test 5: a request every 3 cycles for 60 cycles; the timestamp wraps.
    start_test(0);
    for (int i = 0; i < 60; i++) cycle((i % 3 == 0), 8'($urandom), 1'b1);
    for (int i = 0; i < 6; i++)  cycle(1'b0, 8'h00, 1'b1);

    // Test 6: LATENCY=1 with a held high for 5 cycles.
    start_test(2);
    for (int i = 0; i < 9; i++) begin
      cycle((i >= 1 && i <= 5), 8'(8'hA0 + i), 1'b1);
      if (i >= 2 && i <= 6) check("t6_b_run", int'(s_b), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
